// File: rtl/uart_dma_pkg.sv
// Shared types and message-buffer constants for the UART RX to RAM DMA.
// The constants are also used by the CPU address map.
package uart_dma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } dma_state_t;

  localparam int unsigned MSG_LEN_DEF   = 3;
  localparam logic [7:0]  BASE_ADDR_DEF = 8'h00;

endpackage

// File: rtl/uart_rx_dma.sv
// Moves bytes from the UART RX FIFO into a fixed RAM message buffer, one byte
// per bus tenure, and flags each completed message until the CPU acknowledges it.
module uart_rx_dma
  import uart_dma_pkg::*;
#(
  parameter int unsigned       MSG_LEN   = MSG_LEN_DEF,
  parameter int unsigned       ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
  parameter int unsigned       IDX_W     = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        RX_Data,
  input  logic              RX_Empty,
  output logic              RX_Read,
  output logic              Bus_Req,
  input  logic              Bus_Grant,
  output logic [ADDR_W-1:0] Address,
  output logic [7:0]        Databus_Out,
  output logic              Write_En,
  output logic              Msg_Ready,
  output logic              Msg_Pending,
  input  logic              Msg_Ack,
  output dma_state_t        State_Dbg,
  output logic [IDX_W-1:0]  Idx_Dbg
);

  dma_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             ready_q;
  logic             pending_q;

  logic write_fire;
  logic last_byte;

  // Handshakes: a byte moves only in a cycle where WRITE and Bus_Grant are both
  // high; that same cycle pops the FIFO (RX_Read) and strobes the RAM (Write_En).
  // A grant dropped during WRITE cancels the beat and the request is reissued.
  assign write_fire = (state_q == WRITE) && Bus_Grant;
  assign last_byte  = (idx_q == IDX_W'(MSG_LEN - 1));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      ready_q <= write_fire && last_byte;

      // Setting the flag beats an ack arriving in the completion pulse cycle.
      if (write_fire && last_byte) begin
        pending_q <= 1'b1;
      end else if (Msg_Ack && !ready_q) begin
        pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!RX_Empty && !(pending_q && idx_q == '0)) begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (Bus_Grant) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (Bus_Grant) begin
            idx_q   <= last_byte ? '0 : idx_q + 1'b1;
            state_q <= RELEASE;
          end else begin
            state_q <= REQ;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Bus_Req     = (state_q == REQ) || (state_q == WRITE);
  assign Write_En    = write_fire;
  assign RX_Read     = write_fire;
  assign Address     = write_fire ? (BASE_ADDR + ADDR_W'(idx_q)) : '0;
  assign Databus_Out = write_fire ? RX_Data : 8'h00;
  assign Msg_Ready   = ready_q;
  assign Msg_Pending = pending_q;
  assign State_Dbg   = state_q;
  assign Idx_Dbg     = idx_q;

endmodule

// File: doc/uart_rx_dma.md
Name: uart_rx_dma

Overview:
- Drains received bytes from the UART RX FIFO into a fixed message buffer in data RAM.
- Acquires the shared RAM bus with a request/grant handshake and writes one byte per bus tenure.
- After MSG_LEN bytes are stored, raises a message-ready pulse and holds a pending flag until the CPU acknowledges it.
- Sits directly downstream of the UART receive side (Data_Out/Empty/Data_Read) and upstream of the RAM arbiter.

Parameters:
MSG_LEN, 3, bytes per message; legal range 1..2**IDX_W.
BASE_ADDR, 8'h00, RAM address of message byte 0.
ADDR_W, 8, RAM address width.
IDX_W, 2, width of the byte-index counter; must satisfy 2**IDX_W >= MSG_LEN.

Ports:
Clk  in  1  system clock; all logic on its rising edge.
Rst  in  1  synchronous reset, active-high.
RX_Data  in  8  head byte of the UART RX FIFO; first-word-fall-through, valid whenever RX_Empty=0.
RX_Empty  in  1  UART RX FIFO empty.
RX_Read  out  1  one-cycle pop strobe to the UART RX FIFO (connects to Data_Read).
Bus_Req  out  1  RAM bus request.
Bus_Grant  in  1  RAM bus grant from the arbiter.
Address  out  ADDR_W  RAM write address; 0 when not writing.
Databus_Out  out  8  RAM write data; 0 when not writing.
Write_En  out  1  RAM write strobe.
Msg_Ready  out  1  one-cycle pulse: a full message is in RAM.
Msg_Pending  out  1  level: message unconsumed; held until Msg_Ack.
Msg_Ack  in  1  CPU has consumed the message; clears Msg_Pending.

Behaviour:
- Interface: one clock, Clk; reset Rst is synchronous and active-high.
- Reset (Rst=1 at a rising edge):
  - All outputs go to 0, state goes to IDLE, idx goes to 0, Msg_Pending goes to 0.
  - Reset mid-operation abandons any partial message. A byte already written stays in RAM but is not counted.
  - No pop occurs on the reset cycle.
- FSM states: IDLE, REQ, WRITE, RELEASE.
- IDLE:
  - Bus_Req=0.
  - Go to REQ when RX_Empty=0 and not (Msg_Pending=1 and idx=0).
  - A pending, unacknowledged message blocks the start of the next message, so the buffer is never overwritten. Bytes accumulate in the UART FIFO meanwhile.
- REQ:
  - Bus_Req=1.
  - Go to WRITE on the cycle after Bus_Grant=1 is sampled.
  - Wait indefinitely while Bus_Grant=0.
- WRITE: exactly one cycle, with Bus_Req=1.
  - If Bus_Grant=1 in this cycle:
    - Write_En=1, Address=BASE_ADDR+idx (mod 2**ADDR_W), Databus_Out=RX_Data, RX_Read=1.
    - idx increments.
    - If idx was MSG_LEN-1: idx wraps to 0 and Msg_Ready pulses in the following cycle.
    - Go to RELEASE.
  - If Bus_Grant=0 in this cycle (grant revoked): Write_En=0, RX_Read=0, no idx change; go back to REQ.
- RELEASE:
  - Bus_Req=0 for one cycle, which gives the arbiter a turnaround; then go to IDLE.
  - A byte therefore costs at least 4 cycles (IDLE, REQ, WRITE, RELEASE). Back-to-back bytes each re-request the bus.
- Msg_Ready / Msg_Pending:
  - Msg_Ready is high for exactly one cycle, the cycle after the final WRITE.
  - Msg_Pending is set in that same cycle.
  - Msg_Ack=1 clears Msg_Pending on the next edge.
  - Msg_Ack in the same cycle as Msg_Ready: set wins, so Msg_Pending stays 1.
  - Msg_Ack while Msg_Pending=0 has no effect.
- RX_Empty rising during REQ: impossible by construction, because only this block pops the FIFO. Verification asserts that RX_Read is never 1 when RX_Empty=1.
- Write_En, RX_Read and the nonzero Address/Databus_Out values occur only in WRITE with Bus_Grant=1, always together in one cycle.

Decomposition:
- Package uart_dma_pkg holds:
  - state enum dma_state_t {IDLE, REQ, WRITE, RELEASE};
  - default MSG_LEN and BASE_ADDR constants, shared with the CPU address map.
- Single module; no sub-module is needed. The idx counter and the pending flag are inline.

Test Plan:
1. Three bytes with grant tied high: after reset, push 8'hAA, 8'h03, 8'hCC into the FIFO -> RAM[0..2]=AA,03,CC; Write_En asserted 3 times; Msg_Ready pulses once, 1 cycle after the third write; Msg_Pending=1.
2. Grant latency: hold Bus_Grant=0 for 20 cycles after Bus_Req rises -> no Write_En and no RX_Read during the wait; write occurs 1 cycle after Grant; Bus_Req=0 in RELEASE.
3. Grant revoked in WRITE: drop Bus_Grant exactly in the WRITE cycle -> no write, no pop, FSM back in REQ, idx unchanged; byte written correctly after re-grant.
4. Pending blocks: six bytes queued, no Msg_Ack -> first 3 written, then IDLE with Bus_Req=0 and FIFO holding 3 bytes; pulse Msg_Ack -> bytes 4..6 land at RAM[0..2], second Msg_Ready.
5. Reset mid-message: Rst=1 after 2 bytes written -> all outputs 0, idx=0; next 3 bytes 8'h11, 8'h22, 8'h33 land at RAM[0..2] and produce one Msg_Ready.
6. Ack collision: assert Msg_Ack in the Msg_Ready cycle -> Msg_Pending remains 1; a further Msg_Ack clears it.
